// File: rtl/rvx_bus_pkg.sv
// rvx data-bus mux shared definitions.
// FSM encoding, unmapped read data, index-width helper.
package rvx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_PENDING,
    ST_WRITE_PENDING,
    ST_UNMAPPED_READ,
    ST_UNMAPPED_WRITE
  } bus_state_e;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0;

  // ceil(log2(n)), but never below one bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rvx_bus_mux_if.sv
// rvx data-bus mux bundle: core-side manager
// signals plus the per-subordinate device signals.
interface rvx_bus_mux_if #(
  parameter int NUM_DEVICES = 2
);

  logic [31:0]              manager_address;
  logic                     manager_rrequest;
  logic                     manager_wrequest;
  logic [31:0]              manager_wdata;
  logic [3:0]               manager_wstrobe;
  logic [31:0]              manager_rdata;
  logic                     manager_rresponse;
  logic                     manager_wresponse;

  logic [31:0]              device_address;
  logic [31:0]              device_wdata;
  logic [3:0]               device_wstrobe;
  logic [NUM_DEVICES-1:0]   device_rrequest;
  logic [NUM_DEVICES-1:0]   device_wrequest;
  logic [32*NUM_DEVICES-1:0] device_rdata;
  logic [NUM_DEVICES-1:0]   device_rresponse;
  logic [NUM_DEVICES-1:0]   device_wresponse;

  modport master (
    output manager_address, manager_rrequest,
    output manager_wrequest, manager_wdata,
    output manager_wstrobe,
    input  manager_rdata, manager_rresponse,
    input  manager_wresponse,
    input  device_address, device_wdata,
    input  device_wstrobe,
    input  device_rrequest, device_wrequest,
    output device_rdata, device_rresponse,
    output device_wresponse
  );

  modport slave (
    input  manager_address, manager_rrequest,
    input  manager_wrequest, manager_wdata,
    input  manager_wstrobe,
    output manager_rdata, manager_rresponse,
    output manager_wresponse,
    output device_address, device_wdata,
    output device_wstrobe,
    output device_rrequest, device_wrequest,
    input  device_rdata, device_rresponse,
    input  device_wresponse
  );

endinterface

// File: rtl/rvx_bus_address_decoder.sv
// rvx data-bus address decoder (combinational).
// Lowest-index region wins when regions overlap.
module rvx_bus_address_decoder
  import rvx_bus_pkg::*;
#(
  parameter int NUM_DEVICES = 2,
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_START_ADDRESS =
    {32'h8000_0000, 32'h0000_0000},
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_REGION_SIZE =
    {32'h0000_1000, 32'h0020_0000},
  localparam int SW = clog2_min1(NUM_DEVICES)
) (
  input  logic [31:0]            address,
  output logic [NUM_DEVICES-1:0] hit_sel,
  output logic [SW-1:0]          hit_index,
  output logic                   unmapped
);

  logic [NUM_DEVICES-1:0] hit;

  // wrap-safe region check: offset from base below size
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      hit[i] = (address - DEVICE_START_ADDRESS[32*i +: 32])
             < DEVICE_REGION_SIZE[32*i +: 32];
    end
  end

  // priority pick, scanning down so index 0 lands last
  always_comb begin
    hit_sel   = '0;
    hit_index = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_index  = SW'(i);
      end
    end
  end

  assign unmapped = ~|hit;

endmodule

// File: rtl/rvx_bus_mux.sv
// rvx data-bus mux: one manager to NUM_DEVICES
// subordinates, selection held until response.
module rvx_bus_mux
  import rvx_bus_pkg::*;
#(
  parameter int NUM_DEVICES = 2,
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_START_ADDRESS =
    {32'h8000_0000, 32'h0000_0000},
  parameter logic [32*NUM_DEVICES-1:0] DEVICE_REGION_SIZE =
    {32'h0000_1000, 32'h0020_0000}
) (
  input logic          clock,
  input logic          reset_n,
  rvx_bus_mux_if.slave bus
);

  localparam int SW = clog2_min1(NUM_DEVICES);

  bus_state_e state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;

  logic [NUM_DEVICES-1:0] hit_sel;
  logic [SW-1:0]          hit_index;
  logic                   unmapped;
  logic                   completing;
  logic                   accept;
  logic                   wr_go;
  logic                   rd_go;

  rvx_bus_address_decoder #(
    .NUM_DEVICES         (NUM_DEVICES),
    .DEVICE_START_ADDRESS(DEVICE_START_ADDRESS),
    .DEVICE_REGION_SIZE  (DEVICE_REGION_SIZE)
  ) u_decoder (
    .address  (bus.manager_address),
    .hit_sel  (hit_sel),
    .hit_index(hit_index),
    .unmapped (unmapped)
  );

  // pending transaction finishes this cycle
  always_comb begin
    completing = 1'b0;
    unique case (state_q)
      ST_READ_PENDING:
        completing = bus.device_rresponse[sel_q];
      ST_WRITE_PENDING:
        completing = bus.device_wresponse[sel_q];
      ST_UNMAPPED_READ,
      ST_UNMAPPED_WRITE:
        completing = 1'b1;
      default:
        completing = 1'b0;
    endcase
  end

  // write wins over an illegal simultaneous read
  assign accept = (state_q == ST_IDLE) | completing;
  assign wr_go  = accept & bus.manager_wrequest;
  assign rd_go  = accept & bus.manager_rrequest
                & ~bus.manager_wrequest;

  assign bus.device_address  = bus.manager_address;
  assign bus.device_wdata    = bus.manager_wdata;
  assign bus.device_wstrobe  = bus.manager_wstrobe;
  assign bus.device_rrequest = rd_go ? hit_sel : '0;
  assign bus.device_wrequest = wr_go ? hit_sel : '0;

  // route the selected subordinate's response back
  always_comb begin
    bus.manager_rresponse = 1'b0;
    bus.manager_wresponse = 1'b0;
    bus.manager_rdata     = '0;
    unique case (state_q)
      ST_READ_PENDING: begin
        bus.manager_rresponse = completing;
        if (completing)
          bus.manager_rdata =
            bus.device_rdata[int'(sel_q)*32 +: 32];
      end
      ST_WRITE_PENDING:
        bus.manager_wresponse = completing;
      ST_UNMAPPED_READ: begin
        bus.manager_rresponse = 1'b1;
        bus.manager_rdata     = UNMAPPED_RDATA;
      end
      ST_UNMAPPED_WRITE:
        bus.manager_wresponse = 1'b1;
      default: ;
    endcase
  end

  // next state: complete, then maybe accept back-to-back
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (completing) state_d = ST_IDLE;
    if (wr_go) begin
      state_d = unmapped ? ST_UNMAPPED_WRITE
                         : ST_WRITE_PENDING;
      sel_d   = hit_index;
    end else if (rd_go) begin
      state_d = unmapped ? ST_UNMAPPED_READ
                         : ST_READ_PENDING;
      sel_d   = hit_index;
    end
  end

  // state and held selection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: doc/rvx_bus_mux.md
Name: rvx_bus_mux

Overview:
- Routes the core data bus (one manager) to NUM_DEVICES subordinates: tightly coupled memory, then peripherals.
- Selects the subordinate by address decode on the request cycle.
- Holds that selection until the subordinate responds, so responses with wait states reach the core correctly.
- Sits directly between rvx_core dbus_* and the tightly coupled memory port1 / peripheral ports.

Parameters:
NUM_DEVICES, 2, number of subordinate ports (1..16)
DEVICE_START_ADDRESS, {32'h8000_0000, 32'h0000_0000}, packed 32*NUM_DEVICES, base of region i at bits [32i+31:32i]
DEVICE_REGION_SIZE, {32'h0000_1000, 32'h0020_0000}, packed 32*NUM_DEVICES, region size in bytes, nonzero

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
manager_address  input  32  byte address from core
manager_rrequest  input  1  read request
manager_wrequest  input  1  write request
manager_wdata  input  32  write data
manager_wstrobe  input  4  byte enables
manager_rdata  output  32  read data, valid when manager_rresponse=1
manager_rresponse  output  1  read completion
manager_wresponse  output  1  write completion
device_address  output  32  manager_address broadcast to all subordinates
device_wdata  output  32  manager_wdata broadcast
device_wstrobe  output  4  manager_wstrobe broadcast
device_rrequest  output  NUM_DEVICES  per-device read request
device_wrequest  output  NUM_DEVICES  per-device write request
device_rdata  input  32*NUM_DEVICES  per-device read data
device_rresponse  input  NUM_DEVICES  per-device read completion
device_wresponse  input  NUM_DEVICES  per-device write completion

Behaviour:
- Decode: hit[i] = (manager_address - START[i]) < SIZE[i], unsigned 32-bit compare. Lowest index wins on overlap. No hit means unmapped.
- Request forwarding is combinational (zero latency):
  - device_rrequest[i] = manager_rrequest & hit_sel[i] & accept.
  - device_wrequest[i] follows the same rule using manager_wrequest.
  - accept = state==IDLE, or the pending transaction completes this cycle (back-to-back allowed).
- FSM states: IDLE, READ_PENDING, WRITE_PENDING, UNMAPPED_READ, UNMAPPED_WRITE.
  - IDLE, or completing cycle, with rrequest: go to READ_PENDING, or UNMAPPED_READ if unmapped. Register sel_index.
  - Same condition with wrequest: go to WRITE_PENDING, or UNMAPPED_WRITE if unmapped.
  - READ_PENDING: manager_rresponse = device_rresponse[sel_index]; manager_rdata = device_rdata[sel_index]. On response, go to IDLE unless a new request is accepted in that cycle.
  - WRITE_PENDING: manager_wresponse = device_wresponse[sel_index]; same exit rule.
  - UNMAPPED_READ: exactly one cycle after the request, assert rresponse=1 with rdata=32'h0, then exit. UNMAPPED_WRITE: same with wresponse=1. Data is discarded; no error is signalled.
- Simultaneous rrequest and wrequest is illegal. The write is accepted and the read is dropped.
- A request arriving while pending and not completing is dropped (protocol violation). The bench flags it.
- Responses from non-selected devices, or in IDLE, are ignored. manager_rdata is 32'h0 when not in a read-completing cycle.
- Reset (async assert, sync deassert by upstream reset logic):
  - state=IDLE, sel_index=0.
  - manager_rresponse, manager_wresponse = 0; manager_rdata = 0.
  - Reset mid-transaction abandons it; a late subordinate response after reset is ignored.
- NUM_DEVICES=1 is legal; sel_index is still at least 1 bit wide.

Decomposition:
- Shared package/include rvx_bus_pkg: FSM state encodings, UNMAPPED_RDATA constant (32'h0), and a clog2 helper for sel_index width.
- One sub-module, rvx_bus_address_decoder. It is purely combinational: address → hit vector, one-hot index and unmapped flag, with parameters matching the mux.
- The FSM, response muxing and request gating live in rvx_bus_mux.

Test Plan:
- Read dev0 at 0x0000_0100 with a 1-cycle response returning 32'hCAFE_F00D → device_rrequest=2'b01 in the same cycle; manager_rresponse=1 and rdata=CAFEF00D the next cycle.
- Write 32'h1234_5678, wstrobe 4'hF, to 0x8000_0004 with dev1 wresponse delayed 3 cycles → device_wrequest=2'b10. manager_wresponse rises exactly in the dev1 response cycle; nothing reaches dev0.
- Read 0x4000_0000 (unmapped) → no device_rrequest; one cycle later rresponse=1 and rdata=0. Back in IDLE.
- Back-to-back: dev0 read response cycle carries a new read to 0x8000_0000 → dev1 rrequest asserted in that same cycle; second response routed from dev1.
- Random stall: 10000 cycles with device responses randomly delayed 0–5 cycles → every manager response matches the issued order and data, with no response in IDLE.
- Spurious dev0 rresponse while a dev1 read is pending, then reset_n low during the pending read → the spurious response is ignored. After reset, outputs are 0 and state is IDLE; a late dev1 response produces no manager_rresponse.
